// File: rtl/font_rom_arbiter.sv
// Two-port font ROM arbiter: a high-priority renderer port (A) and a
// low-priority debug port (B) share one pipelined ROM. Port B gets a
// forced grant once it has waited MAX_WAIT cycles. Every accepted read
// returns to its owner LATENCY edges later, in acceptance order.
module font_rom_arbiter #(
  parameter int unsigned ADDR_W   = 7,
  parameter int unsigned DATA_W   = 4,
  parameter int unsigned LATENCY  = 2,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  // port A: video renderer, high priority
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  output logic              a_gnt,
  output logic              a_valid,
  output logic [DATA_W-1:0] a_data,
  // port B: debug/test, low priority
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic              b_gnt,
  output logic              b_valid,
  output logic [DATA_W-1:0] b_data,
  // font ROM side
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  // starvation indicator for port B
  output logic              b_starved
);

  localparam int unsigned WAIT_W = 4;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

  logic [WAIT_W-1:0] wait_q;
  logic [WAIT_W-1:0] wait_d;
  tag_t              tag_q [LATENCY];
  tag_t              tag_in;
  tag_t              tag_out;

  // Grant decision: A wins ties unless B has been starved; nothing granted in reset.
  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (rst_n) begin
      if (b_req && (b_starved || !a_req)) begin
        b_gnt = 1'b1;
      end else if (a_req) begin
        a_gnt = 1'b1;
      end
    end
  end

  // Next B wait count: saturating count of blocked B cycles, cleared otherwise.
  always_comb begin
    wait_d = '0;
    if (b_req && !b_gnt) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);
    end
  end

  // Tag describing this cycle's acceptance, and the tag whose data is due now.
  always_comb begin
    tag_in.valid = a_gnt | b_gnt;
    tag_in.port  = b_gnt ? PORT_B : PORT_A;
    tag_out      = tag_q[LATENCY-1];
  end

  // B wait counter and its registered starvation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_q    <= '0;
      b_starved <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      b_starved <= (wait_d == WAIT_MAX);
    end
  end

  // ROM address register: loads the granted address, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr <= '0;
    end else if (a_gnt) begin
      rom_addr <= a_addr;
    end else if (b_gnt) begin
      rom_addr <= b_addr;
    end
  end

  // Tag shift register tracking which port owns each in-flight read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  // Return path: route ROM data to the owning port with a one-cycle valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_valid <= 1'b0;
      b_valid <= 1'b0;
      a_data  <= '0;
      b_data  <= '0;
    end else begin
      a_valid <= tag_out.valid && (tag_out.port == PORT_A);
      b_valid <= tag_out.valid && (tag_out.port == PORT_B);
      if (tag_out.valid && (tag_out.port == PORT_A)) begin
        a_data <= rom_data;
      end
      if (tag_out.valid && (tag_out.port == PORT_B)) begin
        b_data <= rom_data;
      end
    end
  end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// Bench for font_rom_arbiter: hand-written vector table, contention,
// reset and idle sequences, then random traffic against a queue-based model.
module tb_font_rom_arbiter;

  localparam int ADDR_W   = 7;
  localparam int DATA_W   = 4;
  localparam int LAT      = 2;
  localparam int MAX_WAIT = 8;

  logic              clk;
  logic              rst_n;
  logic              a_req, b_req;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic              a_gnt, b_gnt, a_valid, b_valid, b_starved;
  logic [DATA_W-1:0] a_data, b_data, rom_data, rom_q;
  logic [ADDR_W-1:0] rom_addr;

  font_rom_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LATENCY(LAT), .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt), .a_valid(a_valid), .a_data(a_data),
    .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt), .b_valid(b_valid), .b_data(b_data),
    .rom_addr(rom_addr), .rom_data(rom_data), .b_starved(b_starved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return a[3:0];
  endfunction

  // ROM model: data for an address registered at edge E is sampled at E+2.
  always @(posedge clk) rom_q <= rom_f(rom_addr);
  assign rom_data = rom_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    int                due;
    bit                port;
    logic [ADDR_W-1:0] addr;
  } ret_t;

  ret_t              pend[$];
  int                m_cyc;
  int                m_wait;
  logic [ADDR_W-1:0] m_rom_addr;
  logic [DATA_W-1:0] m_a_data, m_b_data;
  logic              m_ga, m_gb;
  logic              s_a_gnt, s_b_gnt;

  task automatic model_reset();
    pend.delete();
    m_wait     = 0;
    m_rom_addr = '0;
    m_a_data   = '0;
    m_b_data   = '0;
  endtask

  // One clock cycle: drive, check grants, clock, update model, check outputs.
  task automatic step(input logic ar, input logic [ADDR_W-1:0] aa,
                      input logic br, input logic [ADDR_W-1:0] ba);
    logic ga, gb, ev_a, ev_b;
    ret_t r;
    a_req = ar; a_addr = aa; b_req = br; b_addr = ba;
    #1;
    ga = 1'b0; gb = 1'b0;
    if (ar && br) begin
      if (m_wait == MAX_WAIT) gb = 1'b1; else ga = 1'b1;
    end else if (ar) begin
      ga = 1'b1;
    end else if (br) begin
      gb = 1'b1;
    end
    m_ga = ga; m_gb = gb;
    s_a_gnt = a_gnt; s_b_gnt = b_gnt;
    chk("a_gnt", a_gnt, ga);
    chk("b_gnt", b_gnt, gb);
    @(posedge clk);
    m_cyc++;
    ev_a = 1'b0; ev_b = 1'b0;
    if (pend.size() > 0 && pend[0].due == m_cyc) begin
      r = pend.pop_front();
      if (r.port) begin ev_b = 1'b1; m_b_data = rom_f(r.addr); end
      else        begin ev_a = 1'b1; m_a_data = rom_f(r.addr); end
    end
    if (ga) begin pend.push_back('{due: m_cyc + LAT, port: 1'b0, addr: aa}); m_rom_addr = aa; end
    if (gb) begin pend.push_back('{due: m_cyc + LAT, port: 1'b1, addr: ba}); m_rom_addr = ba; end
    if (br && !gb) m_wait = (m_wait == MAX_WAIT) ? m_wait : m_wait + 1;
    else           m_wait = 0;
    #1;
    chk("rom_addr", rom_addr, m_rom_addr);
    chk("a_valid", a_valid, ev_a);
    chk("a_data", a_data, m_a_data);
    chk("b_valid", b_valid, ev_b);
    chk("b_data", b_data, m_b_data);
    chk("b_starved", b_starved, (m_wait == MAX_WAIT));
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_a_valid"}, a_valid, 0);
    chk({tag, "_b_valid"}, b_valid, 0);
    chk({tag, "_a_data"}, a_data, 0);
    chk({tag, "_b_data"}, b_data, 0);
    chk({tag, "_b_starved"}, b_starved, 0);
    chk({tag, "_a_gnt"}, a_gnt, 0);
    chk({tag, "_b_gnt"}, b_gnt, 0);
  endtask

  typedef struct {
    logic              ar;
    logic [ADDR_W-1:0] aa;
    logic              br;
    logic [ADDR_W-1:0] ba;
    logic              ea_gnt, eb_gnt, ea_valid, eb_valid;
    logic [DATA_W-1:0] ea_data, eb_data;
  } vec_t;

  vec_t vecs[17];

  logic              ra, rb, ra_pend, rb_pend;
  logic [ADDR_W-1:0] ra_addr, rb_addr;

  initial begin
    // ar aa br ba | a_gnt b_gnt a_valid b_valid a_data b_data
    vecs[0]  = '{1, 7'h15, 0, 7'h00, 1, 0, 0, 0, 4'h0, 4'h0};
    vecs[1]  = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 4'h0, 4'h0};
    vecs[2]  = '{0, 7'h00, 0, 7'h00, 0, 0, 1, 0, 4'h5, 4'h0};
    vecs[3]  = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 4'h5, 4'h0};
    vecs[4]  = '{1, 7'h01, 0, 7'h00, 1, 0, 0, 0, 4'h5, 4'h0};
    vecs[5]  = '{1, 7'h02, 0, 7'h00, 1, 0, 0, 0, 4'h5, 4'h0};
    vecs[6]  = '{1, 7'h03, 0, 7'h00, 1, 0, 1, 0, 4'h1, 4'h0};
    vecs[7]  = '{0, 7'h00, 0, 7'h00, 0, 0, 1, 0, 4'h2, 4'h0};
    vecs[8]  = '{0, 7'h00, 0, 7'h00, 0, 0, 1, 0, 4'h3, 4'h0};
    vecs[9]  = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 4'h3, 4'h0};
    vecs[10] = '{1, 7'h2A, 0, 7'h00, 1, 0, 0, 0, 4'h3, 4'h0};
    vecs[11] = '{0, 7'h00, 1, 7'h4C, 0, 1, 0, 0, 4'h3, 4'h0};
    vecs[12] = '{0, 7'h00, 0, 7'h00, 0, 0, 1, 0, 4'hA, 4'h0};
    vecs[13] = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 1, 4'hA, 4'hC};
    vecs[14] = '{1, 7'h11, 1, 7'h22, 1, 0, 0, 0, 4'hA, 4'hC};
    vecs[15] = '{0, 7'h00, 0, 7'h00, 0, 0, 0, 0, 4'hA, 4'hC};
    vecs[16] = '{0, 7'h00, 0, 7'h00, 0, 0, 1, 0, 4'h1, 4'hC};

    // Reset state, with both requests high to confirm grants are gated
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_addr = 7'h55; b_addr = 7'h66;
    m_cyc = 0;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    rst_n = 1'b1;
    a_req = 1'b0; b_req = 1'b0;

    // Vector table: single read, back-to-back, interleave, tie
    for (int i = 0; i < 17; i++) begin
      step(vecs[i].ar, vecs[i].aa, vecs[i].br, vecs[i].ba);
      chk($sformatf("vec%0d_a_gnt", i), s_a_gnt, vecs[i].ea_gnt);
      chk($sformatf("vec%0d_b_gnt", i), s_b_gnt, vecs[i].eb_gnt);
      chk($sformatf("vec%0d_a_valid", i), a_valid, vecs[i].ea_valid);
      chk($sformatf("vec%0d_b_valid", i), b_valid, vecs[i].eb_valid);
      chk($sformatf("vec%0d_a_data", i), a_data, vecs[i].ea_data);
      chk($sformatf("vec%0d_b_data", i), b_data, vecs[i].eb_data);
    end

    // Contention: A wins MAX_WAIT cycles, then B is forced through
    for (int k = 1; k <= MAX_WAIT; k++) begin
      step(1'b1, 7'h10, 1'b1, 7'h33);
      chk($sformatf("cont%0d_a_gnt", k), s_a_gnt, 1);
      chk($sformatf("cont%0d_starved", k), b_starved, (k == MAX_WAIT));
    end
    step(1'b1, 7'h10, 1'b1, 7'h33);
    chk("forced_b_gnt", s_b_gnt, 1);
    chk("forced_a_gnt", s_a_gnt, 0);
    chk("starved_clear", b_starved, 0);
    step(1'b1, 7'h11, 1'b0, 7'h00);
    chk("a_resume", s_a_gnt, 1);
    for (int k = 0; k < 3; k++) step(1'b0, 7'h00, 1'b0, 7'h00);

    // Reset mid-flight: in-flight read must never return
    step(1'b1, 7'h3C, 1'b0, 7'h00);
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    #1;
    check_reset_values("mid");
    @(posedge clk);
    #1;
    check_reset_values("mid_edge");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 7'h07, 1'b0, 7'h00);
    chk("post_reset_accept", s_a_gnt, 1);
    for (int k = 0; k < 4; k++) step(1'b0, 7'h00, 1'b0, 7'h00);

    // Idle: address holds, nothing granted or returned
    for (int k = 0; k < 20; k++) step(1'b0, 7'h00, 1'b0, 7'h00);
    chk("idle_rom_addr_hold", rom_addr, 7'h07);

    // Random traffic; a requester holds request and address until granted
    ra_pend = 1'b0; rb_pend = 1'b0;
    ra_addr = '0; rb_addr = '0;
    for (int n = 0; n < 600; n++) begin
      if (!ra_pend) begin
        ra = ($urandom_range(0, 99) < 85);
        ra_addr = ADDR_W'($urandom);
      end
      if (!rb_pend) begin
        rb = ($urandom_range(0, 99) < 50);
        rb_addr = ADDR_W'($urandom);
      end
      step(ra, ra_addr, rb, rb_addr);
      ra_pend = ra && !m_ga;
      rb_pend = rb && !m_gb;
    end
    for (int k = 0; k < 4; k++) step(1'b0, 7'h00, 1'b0, 7'h00);
    chk("drain_empty", pend.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
